// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and helpers for the packet arbiter slice.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package axis_noc_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Round-robin successor: (ptr+1) mod n, wrapping n-1 back to 0.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1) % n;
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream bundle with LANES parallel channels (LANES=1 for the NoC-facing side).
// Latency: none, wires only.
// Backpressure: tready flows from the slave modport back to the master modport.
interface axis_packet_arbiter_if #(
    parameter int LANES = 1,
    parameter int DW    = 512,
    parameter int IW    = 2,
    parameter int DSTW  = 4
);
    logic [LANES-1:0]           tvalid;
    logic [LANES-1:0]           tready;
    logic [LANES-1:0][DW-1:0]   tdata;
    logic [LANES-1:0]           tlast;
    logic [LANES-1:0][IW-1:0]   tid;
    logic [LANES-1:0][DSTW-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_packet_arbiter_skid.sv
// Two-entry skid buffer that breaks the valid/ready paths between its two sides.
// Latency: 1 cycle from input handshake to output valid, full throughput.
// Backpressure: i_up_rdy is registered (low only when the skid entry is occupied).
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_up_vld,
    output logic             o_up_rdy,
    input  logic [WIDTH-1:0] i_up_dat,
    output logic             o_dn_vld,
    input  logic             i_dn_rdy,
    output logic [WIDTH-1:0] o_dn_dat
);
    logic             r_m_vld;
    logic [WIDTH-1:0] r_m_dat;
    logic             r_s_vld;
    logic [WIDTH-1:0] r_s_dat;

    assign o_up_rdy = ~r_s_vld;
    assign o_dn_vld = r_m_vld;
    assign o_dn_dat = r_m_dat;

    // Main entry refills from skid first, otherwise from input; skid only catches a beat during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_vld <= 1'b0;
            r_m_dat <= '0;
            r_s_vld <= 1'b0;
            r_s_dat <= '0;
        end else if (!r_m_vld || i_dn_rdy) begin
            if (r_s_vld) begin
                r_m_vld <= 1'b1;
                r_m_dat <= r_s_dat;
                r_s_vld <= 1'b0;
            end else begin
                r_m_vld <= i_up_vld;
                r_m_dat <= i_up_dat;
            end
        end else if (i_up_vld && !r_s_vld) begin
            r_s_vld <= 1'b1;
            r_s_dat <= i_up_dat;
        end
    end
endmodule

// File: rtl/axis_packet_arbiter.sv
// Round-robin whole-packet arbiter, NUM_INPUTS AXI-Stream requesters onto one port (optional: AXIS_PACKET_ARBITER_OUTPUT_REG_EN).
// Latency: 0 cycles pass-through once locked (+1 with the output skid), 1-cycle arbitration bubble per packet.
// Backpressure: only the granted requester sees the downstream ready; grant is held until the tlast handshake.
module axis_packet_arbiter
    import axis_noc_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 4,
    parameter bit TAG_TID     = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    axis_packet_arbiter_if.slave          s_axis,
    axis_packet_arbiter_if.master         m_axis,
    output logic                          grant_valid,
    output logic [$clog2(NUM_INPUTS)-1:0] grant_idx
);
    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam int PKT_W = TDATA_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH;

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [IDX_W-1:0]        r_grant_idx;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        w_pick_idx;
    logic                    w_pick_vld;
    logic [2*NUM_INPUTS-1:0] w_req_dbl;
    logic [NUM_INPUTS-1:0]   w_req_rot;

    logic                    w_up_vld;
    logic                    w_up_rdy;
    logic                    w_up_lst;
    logic [TDATA_WIDTH-1:0]  w_up_dat;
    logic [TID_WIDTH-1:0]    w_up_tid;
    logic [TDEST_WIDTH-1:0]  w_up_dst;
    logic                    w_hs;

    // Rotate the request vector so that the rr_ptr input sits at bit 0.
    assign w_req_dbl = {s_axis.tvalid, s_axis.tvalid};
    assign w_req_rot = w_req_dbl[r_rr_ptr +: NUM_INPUTS];

    // Priority encoder: lowest set bit of the rotated vector, mapped back to an input index.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = IDX_W'((int'(r_rr_ptr) + k) % NUM_INPUTS);
            end
        end
    end

    // State register, grant latch on arbitration, pointer advance on end of packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB_IDLE && w_pick_vld) begin
                r_grant_idx <= w_pick_idx;
            end
            if (w_hs && w_up_lst) begin
                r_rr_ptr <= IDX_W'(rr_next(int'(r_grant_idx), NUM_INPUTS));
            end
        end
    end

    // Next state: lock on any request, release only on the tlast handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:   if (w_pick_vld)        w_state_nxt = ARB_LOCKED;
            ARB_LOCKED: if (w_hs && w_up_lst)  w_state_nxt = ARB_IDLE;
            default:                           w_state_nxt = ARB_IDLE;
        endcase
    end

    // Outputs: mux the granted requester through and route ready back only to it.
    always_comb begin
        s_axis.tready = '0;
        w_up_vld      = 1'b0;
        w_up_dat      = s_axis.tdata[r_grant_idx];
        w_up_lst      = s_axis.tlast[r_grant_idx];
        w_up_dst      = s_axis.tdest[r_grant_idx];
        w_up_tid      = (TAG_TID != 1'b0) ? TID_WIDTH'(r_grant_idx) : s_axis.tid[r_grant_idx];
        if (r_state == ARB_LOCKED) begin
            w_up_vld                   = s_axis.tvalid[r_grant_idx];
            s_axis.tready[r_grant_idx] = w_up_rdy;
        end
    end

    assign w_hs        = w_up_vld & w_up_rdy;
    assign grant_valid = (r_state == ARB_LOCKED);
    assign grant_idx   = r_grant_idx;

`ifdef AXIS_PACKET_ARBITER_OUTPUT_REG_EN
    logic             w_sk_vld;
    logic [PKT_W-1:0] w_sk_dat;

    axis_skid_buffer #(.WIDTH(PKT_W)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_up_vld (w_up_vld),
        .o_up_rdy (w_up_rdy),
        .i_up_dat ({w_up_dat, w_up_lst, w_up_tid, w_up_dst}),
        .o_dn_vld (w_sk_vld),
        .i_dn_rdy (m_axis.tready[0]),
        .o_dn_dat (w_sk_dat)
    );

    assign m_axis.tvalid[0] = w_sk_vld;
    assign {m_axis.tdata[0], m_axis.tlast[0], m_axis.tid[0], m_axis.tdest[0]} = w_sk_dat;
`else
    assign w_up_rdy         = m_axis.tready[0];
    assign m_axis.tvalid[0] = w_up_vld;
    assign m_axis.tdata[0]  = w_up_dat;
    assign m_axis.tlast[0]  = w_up_lst;
    assign m_axis.tid[0]    = w_up_tid;
    assign m_axis.tdest[0]  = w_up_dst;
`endif
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: one pass-through instance and one tid-tagging instance share stimulus.
// Latency: checks sampled 1 time unit after each falling edge.
// Backpressure: m_axis_tready driven directly by the stimulus sequence.
module tb_axis_packet_arbiter;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int IW   = 2;
    localparam int DSTW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       gv0, gv1;
    logic [1:0] gi0, gi1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    axis_packet_arbiter_if #(.LANES(N), .DW(DW), .IW(IW), .DSTW(DSTW)) s0 ();
    axis_packet_arbiter_if #(.LANES(1), .DW(DW), .IW(IW), .DSTW(DSTW)) m0 ();
    axis_packet_arbiter_if #(.LANES(N), .DW(DW), .IW(IW), .DSTW(DSTW)) s1 ();
    axis_packet_arbiter_if #(.LANES(1), .DW(DW), .IW(IW), .DSTW(DSTW)) m1 ();

    assign s1.tvalid = s0.tvalid;
    assign s1.tdata  = s0.tdata;
    assign s1.tlast  = s0.tlast;
    assign s1.tid    = s0.tid;
    assign s1.tdest  = s0.tdest;
    assign m1.tready = m0.tready;

    axis_packet_arbiter #(.NUM_INPUTS(N), .TDATA_WIDTH(DW), .TID_WIDTH(IW),
                          .TDEST_WIDTH(DSTW), .TAG_TID(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_axis(s0), .m_axis(m0),
        .grant_valid(gv0), .grant_idx(gi0));

    axis_packet_arbiter #(.NUM_INPUTS(N), .TDATA_WIDTH(DW), .TID_WIDTH(IW),
                          .TDEST_WIDTH(DSTW), .TAG_TID(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_axis(s1), .m_axis(m1),
        .grant_valid(gv1), .grant_idx(gi1));

    function automatic logic [31:0] dat(input int i, input int b);
        return 32'hA000_0000 | 32'(i << 8) | 32'(b);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester i presents beat b of a packet; tid = 3-i so pass-through differs from the index tag.
    task automatic src(input int i, input logic v, input int b, input logic l);
        s0.tvalid[i] = v;
        s0.tdata[i]  = dat(i, b);
        s0.tlast[i]  = l;
        s0.tid[i]    = 2'(3 - i);
        s0.tdest[i]  = 4'(i + 4);
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) src(i, 1'b0, 0, 1'b0);
    endtask

    task automatic ctl(input string tag, input logic gv, input int gi, input logic mv, input logic [3:0] rdy);
        chk(tag, 64'({gv0, gi0, m0.tvalid[0], s0.tready, gv1, gi1}),
                 64'({gv, 2'(gi), mv, rdy, gv, 2'(gi)}));
    endtask

    task automatic beat(input string tag, input int i, input int b, input logic l);
        chk(tag, 64'({m0.tlast[0], m0.tid[0], m1.tid[0], m0.tdest[0], m0.tdata[0]}),
                 64'({l, 2'(3 - i), 2'(i), 4'(i + 4), dat(i, b)}));
    endtask

    initial begin
        int  b;
        int  hs;
        int  prev;
        logic r;
        logic [7:0] vv;
        idle_all();
        m0.tready = 1'b1;
        repeat (2) @(negedge clk);
        #1 ctl("reset_state", 1'b0, 0, 1'b0, 4'b0000);
        @(negedge clk); rst_n = 1'b1;
        #1 ctl("post_reset_idle", 1'b0, 0, 1'b0, 4'b0000);
`ifndef AXIS_PACKET_ARBITER_OUTPUT_REG_EN
        // One-beat packet on input 2 moves rr_ptr to 3, then a reset lands mid-packet.
        @(negedge clk); src(2, 1'b1, 0, 1'b1);
        #1 ctl("t1_bubble", 1'b0, 0, 1'b0, 4'b0000);
        @(negedge clk);
        #1 ctl("t1_lock_1beat", 1'b1, 2, 1'b1, 4'b0100);
        beat("t1_beat", 2, 0, 1'b1);
        @(negedge clk); src(2, 1'b1, 0, 1'b0);
        #1 ctl("t1_idle_after_tlast", 1'b0, 2, 1'b0, 4'b0000);
        @(negedge clk);
        #1 ctl("t1_relock", 1'b1, 2, 1'b1, 4'b0100);
        @(negedge clk); src(2, 1'b1, 1, 1'b0); rst_n = 1'b0;
        #1 ctl("t1_reset_mid_packet", 1'b0, 0, 1'b0, 4'b0000);
        @(negedge clk); idle_all(); rst_n = 1'b1;
        #1 ctl("t1_after_release", 1'b0, 0, 1'b0, 4'b0000);

        // All inputs stream 3-beat packets; grants must run 0,1,2,3,0 at 4 cycles each.
        for (int p = 0; p < 5; p++) begin
            prev = (p == 0) ? 0 : (p - 1) % N;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++)
                    src(i, 1'b1, (i == p % N && c > 0) ? c - 1 : 0, (i == p % N && c == 3));
                #1;
                if (c == 0) begin
                    ctl("t2_bubble", 1'b0, prev, 1'b0, 4'b0000);
                end else begin
                    ctl("t2_lock", 1'b1, p % N, 1'b1, 4'(1 << (p % N)));
                    beat("t2_beat", p % N, c - 1, (c == 3));
                end
            end
        end

        // Input 1 sends 5 beats with gaps; input 3 asks mid-packet and must wait for tlast.
        vv = 8'b1011_0101;
        @(negedge clk); idle_all(); src(1, 1'b1, 0, 1'b0);
        #1 ctl("t3_bubble", 1'b0, 0, 1'b0, 4'b0000);
        b = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            src(1, vv[c], b, (b == 4));
            if (c >= 2) src(3, 1'b1, 0, 1'b1);
            #1 ctl("t3_lock_gaps", 1'b1, 1, vv[c], 4'b0010);
            if (vv[c]) begin
                beat("t3_beat", 1, b, (b == 4));
                b++;
            end
        end
        @(negedge clk); src(1, 1'b0, 0, 1'b0);
        #1 ctl("t3_waiter_bubble", 1'b0, 1, 1'b0, 4'b0000);
        @(negedge clk);
        #1 ctl("t3_grant_waiter", 1'b1, 3, 1'b1, 4'b1000);
        beat("t5_tid_tag", 3, 0, 1'b1);

        // Input 0 sends 4 beats while the output ready toggles.
        @(negedge clk); idle_all(); src(0, 1'b1, 0, 1'b0);
        #1 ctl("t4_bubble", 1'b0, 3, 1'b0, 4'b0000);
        b = 0;
        hs = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            r = (c % 2 == 0);
            m0.tready = r;
            src(0, 1'b1, b, (b == 3));
            #1 ctl("t4_stall", 1'b1, 0, 1'b1, {3'b000, r});
            beat("t4_hold", 0, b, (b == 3));
            if (m0.tvalid[0] && m0.tready[0]) begin
                hs++;
                b++;
            end
        end
        chk("t4_handshakes", 64'(hs), 64'd4);
        @(negedge clk); m0.tready = 1'b1;
        for (int i = 0; i < N; i++) src(i, 1'b1, 0, 1'b0);
        #1 ctl("t4_idle", 1'b0, 0, 1'b0, 4'b0000);
        @(negedge clk);
        #1 ctl("t4_rr_ptr_is_1", 1'b1, 1, 1'b1, 4'b0010);
`else
        // Registered output: first beat 2 cycles after the request, then 8 beats back to back.
        @(negedge clk); src(0, 1'b1, 0, 1'b0);
        #1 ctl("t6_request", 1'b0, 0, 1'b0, 4'b0000);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 8) src(0, 1'b1, k - 1, (k == 8));
            else        src(0, 1'b0, 0, 1'b0);
            #1;
            if (k == 1) begin
                chk("t6_latency", 64'(m0.tvalid[0]), 64'd0);
            end else begin
                chk("t6_valid", 64'(m0.tvalid[0]), 64'd1);
                beat("t6_beat", 0, k - 2, (k == 9));
            end
            if (k <= 8) chk("t6_ready", 64'(s0.tready), 64'h1);
        end
        @(negedge clk);
        #1 chk("t6_drain", 64'({m0.tvalid[0], gv0}), 64'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
